// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock/reset controller.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_BURST = 2'd2,
    MODE_HALT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_RSTHOLD = 2'd0,
    S_RUN     = 2'd1,
    S_IDLE    = 2'd2,
    S_STEP    = 2'd3
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Step button synchroniser and debouncer.
// Emits a one-cycle press on a debounced rising level.
module btn_debounce #(
  parameter int DEBOUNCE = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt   <= '0;
        level <= s2;
        press <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock divider, step/burst sequencer and CPU reset generator.
// Single clk50M domain; all outputs registered.
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W     = 25,
  parameter int BURST_W   = 16,
  parameter int CNT_W     = 32,
  parameter int DEBOUNCE  = 500000,
  parameter int RST_EDGES = 4
) (
  input  logic               clk50M,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               step_btn,
  input  logic               sel,
  output logic               clk_cpu,
  output logic               clk_cpu_rise,
  output logic               cpu_rst,
  output logic               busy,
  output logic [CNT_W-1:0]   cycle_cnt
);

  localparam int EW = $clog2(RST_EDGES + 1);

  state_e             state;
  state_e             nstate;
  mode_e              m;
  logic [DIV_W-1:0]   cnt;
  logic [BURST_W-1:0] remain;
  logic [BURST_W-1:0] remain_n;
  logic [EW-1:0]      edges;
  logic [EW-1:0]      edges_n;
  logic               sel_s1;
  logic               sel_s2;
  logic               sel_prev;
  logic               sel_chg;
  logic               press;
  logic               en;
  logic               tick;
  logic               rise;
  logic               fall;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
    .clk   (clk50M),
    .rst   (rst),
    .btn   (step_btn),
    .press (press)
  );

  assign m       = mode_e'(mode);
  assign tick    = en && (cnt >= div);
  assign rise    = tick && !clk_cpu;
  assign fall    = tick && clk_cpu;
  assign sel_chg = sel_s2 ^ sel_prev;

  always_comb begin
    nstate   = state;
    remain_n = remain;
    edges_n  = edges;
    en       = 1'b1;
    unique case (state)
      S_RSTHOLD: begin
        if (rise && edges != EW'(RST_EDGES))
          edges_n = edges + EW'(1);
        if (fall && edges == EW'(RST_EDGES))
          nstate = (m == MODE_RUN) ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (fall && m != MODE_RUN)
          nstate = S_IDLE;
      end
      S_IDLE: begin
        en = 1'b0;
        if (m == MODE_RUN) begin
          nstate = S_RUN;
        end else if (press && m == MODE_STEP) begin
          nstate   = S_STEP;
          remain_n = BURST_W'(1);
        end else if (press && m == MODE_BURST && burst_len != '0) begin
          nstate   = S_STEP;
          remain_n = burst_len;
        end
      end
      S_STEP: begin
        if (fall) begin
          remain_n = remain - BURST_W'(1);
          if (remain == BURST_W'(1))
            nstate = S_IDLE;
        end
      end
      default: ;
    endcase
    // A selector change overrides everything, including a same-cycle press
    if (sel_chg) begin
      nstate  = S_RSTHOLD;
      edges_n = '0;
    end
  end

  always_ff @(posedge clk50M) begin
    sel_s1   <= sel;
    sel_s2   <= sel_s1;
    sel_prev <= sel_s2;
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state        <= S_RSTHOLD;
      edges        <= '0;
      remain       <= '0;
      cnt          <= '0;
      clk_cpu      <= 1'b0;
      clk_cpu_rise <= 1'b0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b0;
      cycle_cnt    <= '0;
    end else begin
      state        <= nstate;
      edges        <= edges_n;
      remain       <= remain_n;
      clk_cpu_rise <= rise;
      cpu_rst      <= (nstate == S_RSTHOLD);
      busy         <= (nstate == S_STEP);
      if (!en) begin
        cnt     <= '0;
        clk_cpu <= 1'b0;
      end else if (tick) begin
        cnt     <= '0;
        clk_cpu <= ~clk_cpu;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      if (nstate == S_RSTHOLD)
        cycle_cnt <= '0;
      else if (rise)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with a short debounce.
module tb_cpu_clk_ctrl;
  import cpu_clk_pkg::*;

  localparam int DIV_W   = 25;
  localparam int BURST_W = 16;
  localparam int CNT_W   = 32;

  logic               clk50M = 1'b0;
  logic               rst;
  logic [1:0]         mode;
  logic [DIV_W-1:0]   div;
  logic [BURST_W-1:0] burst_len;
  logic               step_btn;
  logic               sel;
  logic               clk_cpu;
  logic               clk_cpu_rise;
  logic               cpu_rst;
  logic               busy;
  logic [CNT_W-1:0]   cycle_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int rises;
  int hi;
  int bsy;
  int el;

  cpu_clk_ctrl #(
    .DIV_W     (DIV_W),
    .BURST_W   (BURST_W),
    .CNT_W     (CNT_W),
    .DEBOUNCE  (4),
    .RST_EDGES (4)
  ) dut (
    .clk50M       (clk50M),
    .rst          (rst),
    .mode         (mode),
    .div          (div),
    .burst_len    (burst_len),
    .step_btn     (step_btn),
    .sel          (sel),
    .clk_cpu      (clk_cpu),
    .clk_cpu_rise (clk_cpu_rise),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .cycle_cnt    (cycle_cnt)
  );

  always #5 clk50M = ~clk50M;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk50M);
      if (clk_cpu_rise) rises++;
      if (clk_cpu) hi++;
      if (busy) bsy++;
    end
  endtask

  task automatic clr();
    rises = 0;
    hi    = 0;
    bsy   = 0;
  endtask

  task automatic wait_rise(input string tag, input int budget,
                           output int c);
    c = 0;
    do begin
      run(1);
      c++;
    end while (!clk_cpu_rise && c < budget);
    if (!clk_cpu_rise) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_rst(input string tag, input logic lvl,
                          input int budget, output int c);
    c = 0;
    do begin
      run(1);
      c++;
    end while (cpu_rst !== lvl && c < budget);
    if (cpu_rst !== lvl) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    rst       = 1'b1;
    mode      = MODE_RUN;
    div       = DIV_W'(2);
    burst_len = '0;
    step_btn  = 1'b0;
    sel       = 1'b0;
    clr();
    run(3);
    check("rst_clk", clk_cpu, 0);
    check("rst_rise", clk_cpu_rise, 0);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_cycle", cycle_cnt, 0);

    // board reset release, div=2: rises at 3,9,15,21; exit fall at 24
    rst = 1'b0;
    clr();
    wait_rst("hold", 1'b0, 200, el);
    check("hold_len", el, 24);
    check("hold_rises", rises, 4);
    check("hold_clk", clk_cpu, 0);
    check("hold_cycle", cycle_cnt, 0);
    wait_rise("run1", 50, el);
    check("run_first", el, 3);
    wait_rise("run2", 50, el);
    check("run_period", el, 6);
    for (int i = 0; i < 3; i++) wait_rise("runn", 50, el);
    check("run_cycle5", cycle_cnt, 5);

    // HALT right after a rise with div=3: 4-cycle high phase
    div  = DIV_W'(3);
    mode = MODE_HALT;
    el   = 0;
    while (clk_cpu && el < 50) begin
      el++;
      run(1);
    end
    check("halt_hi", el, 4);
    clr();
    run(30);
    check("halt_rises", rises, 0);
    check("halt_clk", clk_cpu, 0);
    check("halt_busy", busy, 0);
    check("halt_cycle", cycle_cnt, 5);

    // single step, div=1: rise 4+3+2 cycles after press
    mode = MODE_STEP;
    div  = DIV_W'(1);
    clr();
    step_btn = 1'b1;
    wait_rise("step", 60, el);
    check("step_lat", el, 9);
    run(5);
    step_btn = 1'b0;
    run(40);
    check("step_rises", rises, 1);
    check("step_hi", hi, 2);
    check("step_busy", bsy, 4);
    check("step_clk", clk_cpu, 0);
    check("step_cycle", cycle_cnt, 6);

    // burst of 3, burst_len changed mid-burst
    mode      = MODE_BURST;
    burst_len = BURST_W'(3);
    clr();
    step_btn = 1'b1;
    run(12);
    step_btn  = 1'b0;
    burst_len = BURST_W'(9);
    run(50);
    check("burst_rises", rises, 3);
    check("burst_hi", hi, 6);
    check("burst_busy", bsy, 12);
    check("burst_cycle", cycle_cnt, 9);
    check("burst_clk", clk_cpu, 0);

    burst_len = '0;
    clr();
    step_btn = 1'b1;
    run(12);
    step_btn = 1'b0;
    run(50);
    check("burst0_rises", rises, 0);
    check("burst0_busy", bsy, 0);

    // bounce shorter than debounce window
    mode = MODE_STEP;
    clr();
    repeat (3) begin
      step_btn = 1'b1;
      run(3);
      step_btn = 1'b0;
      run(3);
    end
    run(30);
    check("bounce_rises", rises, 0);
    check("bounce_busy", bsy, 0);

    // sel toggle during a burst abandons it
    mode      = MODE_BURST;
    burst_len = BURST_W'(5);
    clr();
    step_btn = 1'b1;
    wait_rise("sb1", 60, el);
    step_btn = 1'b0;
    wait_rise("sb2", 20, el);
    sel = 1'b1;
    wait_rst("sel", 1'b1, 20, el);
    check("sel_lat", el, 3);
    check("sel_busy", busy, 0);
    check("sel_cycle", cycle_cnt, 0);
    clr();
    wait_rst("selh", 1'b0, 200, el);
    check("sel_rises", rises, 4);
    check("sel_clk", clk_cpu, 0);
    check("sel_busy2", busy, 0);
    clr();
    run(30);
    check("sel_idle_rises", rises, 0);
    check("sel_idle_cycle", cycle_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
